// File: rtl/gate_debounce_pkg.sv
// Shared types and defaults for the two-input gate debounce stage.
package gate_debounce_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_e;

endpackage

// File: rtl/gate_input_debounce_channel.sv
// One debounce channel: synchroniser, stability counter, level FSM and update flag.
// GATE_DEBOUNCE_BYPASS_EN drops the counter/FSM and registers the synchronised level directly.
module debounce_channel
  import gate_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic update
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   level_q, level_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  assign s      = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

`ifdef GATE_DEBOUNCE_BYPASS_EN

  always_comb begin
    level_d = s;
    update  = s ^ level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
    end
  end

`else

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    update  = 1'b0;
    unique case (state_q)
      IDLE_LOW: if (s) begin
        state_d = WAIT_HIGH;
        cnt_d   = CNT_W'(1);
      end
      WAIT_HIGH: if (!s) begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = IDLE_HIGH;
        cnt_d   = '0;
        level_d = 1'b1;
        update  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      IDLE_HIGH: if (!s) begin
        state_d = WAIT_LOW;
        cnt_d   = CNT_W'(1);
      end
      WAIT_LOW: if (s) begin
        state_d = IDLE_HIGH;
        cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
        update  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

`endif

endmodule

// File: rtl/gate_input_debounce.sv
// Two independent debounced gate inputs with a shared registered change strobe.
// Optional macro GATE_DEBOUNCE_BYPASS_EN replaces debouncing with a registered synchroniser.
module gate_input_debounce
  import gate_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic changed
);

  logic upd_a, upd_b;
  logic changed_q, changed_d;

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw_a),
    .level (a),
    .update(upd_a)
  );

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw_b),
    .level (b),
    .update(upd_b)
  );

  // Registered on the same edge as the levels, so the strobe lines up with the new a/b.
  assign changed_d = upd_a | upd_b;
  assign changed   = changed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= changed_d;
  end

endmodule

// File: tb/tb_gate_input_debounce.sv
// Scoreboard bench for gate_input_debounce (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_gate_input_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
`ifdef GATE_DEBOUNCE_BYPASS_EN
  localparam int EFF           = 1;
  localparam int EXP_GLITCH_CH = 2;
`else
  localparam int EFF           = STABLE;
  localparam int EXP_GLITCH_CH = 0;
`endif
  localparam int RISE_EDGE = SYNC + EFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic a, b, changed;

  typedef struct packed {
    logic a;
    logic b;
    logic changed;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: synchroniser image, current level, disagreement run length.
  logic [SYNC-1:0] m_sync[2];
  logic            m_out[2];
  int              m_run[2];

  int edge_n, pulses, rise_at, fall_at;
  logic seen_hi;

  gate_input_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .a      (a),
    .b      (b),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at each rising edge: computes the outputs expected just after that edge.
  task automatic model_push();
    obs_t e;
    logic raw_v[2];
    logic s;
    raw_v[0]  = raw_a;
    raw_v[1]  = raw_b;
    e.changed = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        m_sync[ch] = '0;
        m_out[ch]  = 1'b0;
        m_run[ch]  = 0;
      end else begin
        s = m_sync[ch][SYNC-1];
        if (s != m_out[ch]) m_run[ch]++;
        else                m_run[ch] = 0;
        if (m_run[ch] == EFF) begin
          m_out[ch] = ~m_out[ch];
          m_run[ch] = 0;
          e.changed = 1'b1;
        end
        m_sync[ch] = {m_sync[ch][SYNC-2:0], raw_v[ch]};
      end
    end
    e.a = m_out[0];
    e.b = m_out[1];
    exp_q.push_back(e);
  endtask

  task automatic tick(input string tag);
    obs_t e;
    @(posedge clk);
    model_push();
    #1;
    edge_n++;
    if (changed === 1'b1) pulses++;
    check({tag, "_qdepth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_a"}, a, e.a);
      check({tag, "_b"}, b, e.b);
      check({tag, "_changed"}, changed, e.changed);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      m_sync[ch] = '0;
      m_out[ch]  = 1'b0;
      m_run[ch]  = 0;
    end
    edge_n = 0;
    pulses = 0;

    // Reset held with both raw inputs high.
    rst_n = 1'b0; raw_a = 1'b1; raw_b = 1'b1;
    run("reset", 3);
    check("reset_a", a, 0);
    check("reset_b", b, 0);
    rst_n = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
    run("idle", 4);

    // Clean rise on A.
    raw_a = 1'b1; edge_n = 0; pulses = 0; rise_at = -1;
    for (int i = 0; i < 10; i++) begin
      tick("rise");
      if (rise_at < 0 && a === 1'b1) rise_at = edge_n;
    end
    check("rise_edge", rise_at, RISE_EDGE);
    check("rise_pulses", pulses, 1);
    check("rise_b_low", b, 0);
    raw_a = 1'b0;
    run("fall_a", 10);

    // Short glitch on B, then a pulse of exactly STABLE cycles.
    pulses = 0;
    raw_b = 1'b1; run("glitch", 3);
    raw_b = 1'b0; run("glitch", 8);
    check("glitch_pulses", pulses, EXP_GLITCH_CH);
    raw_b = 1'b1; run("pulse4", 4);
    raw_b = 1'b0; edge_n = 0; fall_at = -1; seen_hi = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick("pulse4");
      if (b === 1'b1) seen_hi = 1'b1;
      if (seen_hi && fall_at < 0 && b === 1'b0) fall_at = edge_n;
    end
    check("pulse4_fall_edge", fall_at, RISE_EDGE);

    // Simultaneous rise: single strobe.
    raw_a = 1'b1; raw_b = 1'b1; edge_n = 0; pulses = 0; rise_at = -1;
    for (int i = 0; i < 10; i++) begin
      tick("simul");
      if (rise_at < 0 && a === 1'b1 && b === 1'b1) rise_at = edge_n;
    end
    check("simul_edge", rise_at, RISE_EDGE);
    check("simul_pulses", pulses, 1);
    raw_a = 1'b0; raw_b = 1'b0;
    run("simul_fall", 10);

    // Reset mid-count discards progress.
    raw_a = 1'b1; edge_n = 0; rise_at = -1;
    run("midrst", 4);
    rst_n = 1'b0;
    tick("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick("midrst");
      if (rise_at < 0 && a === 1'b1) rise_at = edge_n;
    end
    check("midrst_edge", rise_at, 5 + RISE_EDGE);
    raw_a = 1'b0;
    run("midrst_fall", 10);

    // Random bursts of varying length on both inputs.
    for (int seg = 0; seg < 80; seg++) begin
      raw_a = 1'($urandom_range(0, 1));
      raw_b = 1'($urandom_range(0, 1));
      run("random", $urandom_range(1, 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_input_debounce.md
# gate_input_debounce

Upstream input-conditioning stage for the two-input gate blocks (AND/NAND/NOR family). It takes two raw, asynchronous switch or pin inputs and synchronises each to `clk`. It debounces each one and presents clean, glitch-free `a` and `b` levels to the downstream gate, plus a one-cycle `changed` strobe whenever either level updates.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel; minimum 2.
- `STABLE_CYCLES`, default 1000: consecutive disagreeing cycles required before an output level updates; minimum 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: debounce counter width.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `raw_a`, input, 1: asynchronous raw input A.
- `raw_b`, input, 1: asynchronous raw input B.
- `a`, output, 1: debounced level A, registered.
- `b`, output, 1: debounced level B, registered.
- `changed`, output, 1: one-cycle pulse, registered, coincident with any update of `a` or `b`.

## Operation
- The two channels are fully independent and identical.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain produces `s`.
- **Per-channel FSM:** `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`.
  - `IDLE_LOW`: `s==1` → `WAIT_HIGH`, count = 1.
  - `WAIT_HIGH`:
    - `s==0` → `IDLE_LOW`, count = 0 (glitch rejected).
    - `s==1` and count == `STABLE_CYCLES-1` → `IDLE_HIGH`, output = 1, count = 0.
    - Otherwise count increments.
  - `IDLE_HIGH` and `WAIT_LOW`: mirror image of the above.
- The output is 1 exactly in `IDLE_HIGH` and `WAIT_LOW`, and is registered.
- `changed` = OR of the two channels' update events, registered alongside the outputs.
  - Both channels updating on the same edge produce a single one-cycle pulse.
- The counter never exceeds `STABLE_CYCLES-1`; no wrap-around is reachable.
- **Reset:** applies when `rst_n==0` at a rising edge.
  - All synchroniser flops = 0; `a` = `b` = 0; `changed` = 0; counters = 0; FSMs = `IDLE_LOW`.
  - Reset mid-count discards progress.
  - After reset, a raw input that is held high requires the full latency again.

## Timing
- Raw level sampled at edge 0 → `s` updates at edge `SYNC_STAGES`.
- Output updates at edge `SYNC_STAGES + STABLE_CYCLES`.
  - Default parameters: 1002 cycles.
- `changed` is high for exactly the one cycle following the update edge, aligned with the new `a`/`b` values.
- Any disagreement run shorter than `STABLE_CYCLES` cycles (measured at `s`) produces no output change and no `changed` pulse.
- Back-to-back transitions: after an update, the opposite transition needs a further `STABLE_CYCLES` cycles. The minimum output pulse width is therefore `STABLE_CYCLES`.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `GATE_DEBOUNCE_BYPASS_EN`.
- **Undefined (default):** full debounce as described above.
- **Defined:** counters and FSMs are not compiled in.
  - `a`/`b` are registered copies of `s`, giving latency `SYNC_STAGES + 1` edges.
  - `changed` pulses on any change of a registered output.
  - `STABLE_CYCLES` is ignored.
  - Reset values are unchanged.

## Structure
- Shared package `gate_debounce_pkg` holds:
  - the FSM state enum (`IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`, 2-bit encoding);
  - default constants `DEF_SYNC_STAGES = 2` and `DEF_STABLE_CYCLES = 1000`.
- One sub-module, `debounce_channel`, containing the synchroniser, counter, FSM and per-channel update flag.
  - It is instantiated twice.
  - The top level ORs the update flags into `changed`.

## Test plan
Unless noted, tests use `SYNC_STAGES=2` and `STABLE_CYCLES=4`.
- **Reset:** hold `rst_n=0` for 3 edges with `raw_a=raw_b=1` → `a=0`, `b=0`, `changed=0` throughout reset.
- **Clean rise:** after reset, `raw_a` 0→1 at edge 0 and held → `a=1` from edge 6, `changed=1` for exactly one cycle, `b` stays 0.
- **Glitch rejection:** `raw_b` high for 3 cycles then low → `b` stays 0 and `changed` never asserts. A second pulse of 4 cycles → `b` rises at the expected edge, then falls 6 edges after `raw_b` drops.
- **Simultaneous update:** `raw_a` and `raw_b` both rise at edge 0 → `a` and `b` both go to 1 at edge 6, with a single one-cycle `changed` pulse.
- **Reset mid-count:** `raw_a` rises at edge 0; `rst_n=0` at edge 4 for 1 cycle, then released with `raw_a` still high.
  - `a` stays 0 until 6 edges after release (edge 11), then `a=1` with a `changed` pulse.
- **Bypass build:** with `GATE_DEBOUNCE_BYPASS_EN` defined, `raw_a` 0→1 at edge 0 → `a=1` at edge 3; a 1-cycle glitch propagates to `a`.
